fmult_pipe: RTL

FMULT_PIPE -- requirements
Module: fmult_pipe

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_round_pack.sv | 87 ++++++++
 rtl/fmult_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point format helpers for the {sign, expo, frac} datapath blocks.
// Packages cannot take parameters, so widths are passed to the constant functions.
package fp_pkg;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int fra_w);
        return (((64'd1 << exp_w) - 64'd1) << fra_w) | (64'd1 << (fra_w - 1));
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise / round-to-nearest-even / pack / classify stage.
// Takes a raw 2*FRA+2-bit significand product so an adder can reuse it later.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP = 5,
    parameter int FRA = 10
) (
    input  logic                     sign,
    input  logic signed [EXP+1:0]    expo,
    input  logic [2*FRA+1:0]         prod,
    input  logic [2:0]               cls,
    output logic [EXP+FRA:0]         y,
    output logic [2:0]               flag
);

    localparam int W    = EXP + FRA + 1;
    localparam int M    = FRA + 1;
    localparam int PW   = 2 * FRA + 2;
    localparam int EW   = EXP + 2;
    localparam int EMAX = fp_emax(EXP);
    localparam logic [W-1:0]   QNAN  = W'(fp_qnan(EXP, FRA));
    localparam logic [EXP-1:0] EONES = '1;

    logic [PW-1:0]        sig;
    logic [PW-1:0]        shifted;
    logic [PW-1:0]        mask;
    logic signed [EW-1:0] e1;
    logic signed [EW-1:0] e_out;
    logic                 sub;
    int                   sh;
    logic [M-1:0]         mant;
    logic                 guard;
    logic                 sticky;
    logic                 rnd;
    logic [M:0]           mant_r;
    logic [FRA-1:0]       frac;

    always_comb begin
        // Product of two normalised significands lies in [1,4): align to [1,2).
        sig = prod[PW-1] ? prod : (prod << 1);
        e1  = prod[PW-1] ? (expo + EW'(1)) : expo;
        sub = (e1 <= 0);

        // Gradual underflow: right shift, keeping everything shifted out as sticky.
        sh = 0;
        if (sub) begin
            sh = 1 - int'(e1);
            if (sh > PW) sh = PW;
        end
        mask    = ~({PW{1'b1}} << sh);
        shifted = sig >> sh;

        mant   = shifted[PW-1:FRA+1];
        guard  = shifted[FRA];
        sticky = (|shifted[FRA-1:0]) | (|(sig & mask));
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{M{1'b0}}, rnd};

        if (sub) begin
            // A carry into the hidden bit promotes the subnormal to expo=1.
            e_out = {{(EW-1){1'b0}}, mant_r[FRA]};
            frac  = mant_r[FRA-1:0];
        end else if (mant_r[M]) begin
            e_out = e1 + EW'(1);
            frac  = '0;
        end else begin
            e_out = e1;
            frac  = mant_r[FRA-1:0];
        end

        y = {sign, e_out[EXP-1:0], frac};
        if (cls[FLAG_NAN]) begin
            y = QNAN;
        end else if (cls[FLAG_INF] || (e_out >= EMAX)) begin
            y = {sign, EONES, {FRA{1'b0}}};
        end else if (cls[FLAG_ZERO]) begin
            y = {sign, {(W-1){1'b0}}};
        end

        flag            = 3'b000;
        flag[FLAG_NAN]  = (y[W-2:FRA] == EONES) && (y[FRA-1:0] != '0);
        flag[FLAG_INF]  = (y[W-2:FRA] == EONES) && (y[FRA-1:0] == '0);
        flag[FLAG_ZERO] = (y[W-2:0] == '0);
    end

endmodule

// File: rtl/fmult_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control:
// S1 unpack/classify/exponent sum, S2 significand product, S3 round and pack.
module fmult_pipe
    import fp_pkg::*;
#(
    parameter int EXP = 5,
    parameter int FRA = 10
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP+FRA:0] A,
    input  logic [EXP+FRA:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP+FRA:0] Y,
    output logic [2:0]       flag
);

    localparam int W    = EXP + FRA + 1;
    localparam int M    = FRA + 1;
    localparam int PW   = 2 * FRA + 2;
    localparam int EW   = EXP + 2;
    localparam int BIAS = fp_bias(EXP);
    localparam logic [EXP-1:0] EONES = '1;

    // Per-operand unpack; subnormals are pre-normalised so S2 always sees a leading one.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_unpack
        logic [W-1:0]         x;
        logic [EXP-1:0]       ex;
        logic [FRA-1:0]       fr;
        logic [M-1:0]         mant;
        logic [M-1:0]         norm_m;
        logic signed [EW-1:0] norm_e;
        logic                 is_nan;
        logic                 is_inf;
        logic                 is_zero;
        int                   lz;

        assign x    = (gi == 0) ? A : B;
        assign ex   = x[W-2:FRA];
        assign fr   = x[FRA-1:0];
        assign mant = {ex != '0, fr};

        always_comb begin
            lz = 0;
            for (int i = 0; i < M; i++) begin
                if (!mant[M-1-i] && (lz == i)) lz = i + 1;
            end
        end

        assign norm_m  = mant << lz;
        assign norm_e  = $signed({2'b00, (ex == '0) ? EXP'(1) : ex}) - EW'(lz);
        assign is_nan  = (ex == EONES) && (fr != '0);
        assign is_inf  = (ex == EONES) && (fr == '0);
        assign is_zero = (ex == '0) && (fr == '0);
    end

    logic [2:0] cls_in;
    always_comb begin
        cls_in            = 3'b000;
        cls_in[FLAG_NAN]  = g_unpack[0].is_nan | g_unpack[1].is_nan
                          | (g_unpack[0].is_inf & g_unpack[1].is_zero)
                          | (g_unpack[0].is_zero & g_unpack[1].is_inf);
        cls_in[FLAG_INF]  = ~cls_in[FLAG_NAN] & (g_unpack[0].is_inf | g_unpack[1].is_inf);
        cls_in[FLAG_ZERO] = ~cls_in[FLAG_NAN] & ~cls_in[FLAG_INF]
                          & (g_unpack[0].is_zero | g_unpack[1].is_zero);
    end

    logic                 s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic                 s1_sign_reg, s2_sign_reg;
    logic signed [EW-1:0] s1_exp_reg, s2_exp_reg;
    logic [M-1:0]         s1_ma_reg, s1_mb_reg;
    logic [PW-1:0]        s2_prod_reg;
    logic [2:0]           s1_cls_reg, s2_cls_reg;
    logic [W-1:0]         y_reg;
    logic [2:0]           flag_reg;
    logic [W-1:0]         rp_y;
    logic [2:0]           rp_flag;
    logic                 en1, en2, en3, accept;

    // A stage may load when it is empty or its content moves on this edge.
    assign en3      = ~s3_valid_reg | out_ready;
    assign en2      = ~s2_valid_reg | en3;
    assign en1      = ~s1_valid_reg | en2;
    assign in_ready = aresetn & en1;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
            y_reg        <= '0;
            flag_reg     <= '0;
        end else begin
            if (en1) s1_valid_reg <= accept;
            if (en2) s2_valid_reg <= s1_valid_reg;
            if (en3) begin
                s3_valid_reg <= s2_valid_reg;
                if (s2_valid_reg) begin
                    y_reg    <= rp_y;
                    flag_reg <= rp_flag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            s1_sign_reg <= A[W-1] ^ B[W-1];
            s1_exp_reg  <= g_unpack[0].norm_e + g_unpack[1].norm_e - EW'(BIAS);
            s1_ma_reg   <= g_unpack[0].norm_m;
            s1_mb_reg   <= g_unpack[1].norm_m;
            s1_cls_reg  <= cls_in;
        end
        if (en2) begin
            s2_sign_reg <= s1_sign_reg;
            s2_exp_reg  <= s1_exp_reg;
            s2_prod_reg <= PW'(s1_ma_reg) * PW'(s1_mb_reg);
            s2_cls_reg  <= s1_cls_reg;
        end
    end

    fp_round_pack #(
        .EXP (EXP),
        .FRA (FRA)
    ) u_round_pack (
        .sign (s2_sign_reg),
        .expo (s2_exp_reg),
        .prod (s2_prod_reg),
        .cls  (s2_cls_reg),
        .y    (rp_y),
        .flag (rp_flag)
    );

    assign out_valid = s3_valid_reg;
    assign Y         = y_reg;
    assign flag      = flag_reg;

endmodule
